alu_pipe: RTL and testbench

Parametrised, handshaked successor to the project's 16-bit combinational ALU. It computes the same flag set (result, carry-out, overflow, zero) for any power-of-two width. Operands and results are exchanged over valid/ready handshakes, and all outputs are registered. It adds an iterative shift-add multiply mode. It sits between the datapath's operand registers and the writeback stage, and can stall the datapath while a multiply is in progress.

---
 rtl/alu_pipe.sv | 173 +++++++++++++++++
 tb/tb_alu_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked, registered ALU: single-cycle add/sub/logic/shift ops plus an
// iterative shift-add multiply that stalls input acceptance while it runs.
module alu_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [SHW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_result;
    logic                 r_co;
    logic                 r_ov;
    logic                 r_zero;
    logic                 r_out_valid;

    op_t                  w_op;
    logic                 w_accept;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [SHW-1:0]       w_amt;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_sll;
    logic [WIDTH:0]       w_srl;
    logic [WIDTH-1:0]     w_res;
    logic                 w_co;
    logic                 w_ov;

    assign w_op       = op_t'(op);
    assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_cnt == SHW'(WIDTH - 1));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Shifts run on WIDTH+1 bits so the extra bit holds the last bit shifted out.
    always_comb begin
        w_amt = b[SHW-1:0];
        w_sum = '0;
        w_sll = '0;
        w_srl = '0;
        w_res = '0;
        w_co  = 1'b0;
        w_ov  = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_sum = {1'b0, a} + {1'b0, b};
                w_res = w_sum[WIDTH-1:0];
                w_co  = w_sum[WIDTH];
                w_ov  = (a[MSB] == b[MSB]) && (w_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                w_res = w_sum[WIDTH-1:0];
                w_co  = w_sum[WIDTH];
                w_ov  = (a[MSB] != b[MSB]) && (w_res[MSB] != a[MSB]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_SLL: begin
                w_sll = {1'b0, a} << w_amt;
                w_res = w_sll[WIDTH-1:0];
                w_co  = w_sll[WIDTH];
            end
            OP_SRL: begin
                w_srl = {a, 1'b0} >> w_amt;
                w_res = w_srl[WIDTH:1];
                w_co  = w_srl[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_op == OP_MUL) w_state_next = S_MUL;
            S_MUL:  if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_result    <= '0;
            r_co        <= 1'b0;
            r_ov        <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                if (w_op == OP_MUL) begin
                    r_mcand     <= {{WIDTH{1'b0}}, a};
                    r_mplier    <= b;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                end else begin
                    r_result    <= w_res;
                    r_co        <= w_co;
                    r_ov        <= w_ov;
                    r_zero      <= (w_res == '0);
                    r_out_valid <= 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + SHW'(1);
            if (w_last) begin
                r_result    <= w_acc_next[WIDTH-1:0];
                r_co        <= 1'b0;
                r_ov        <= |w_acc_next[2*WIDTH-1:WIDTH];
                r_zero      <= (w_acc_next[WIDTH-1:0] == '0);
                r_out_valid <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign co        = r_co;
    assign overflow  = r_ov;
    assign zero      = r_zero;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=16): vector table for single-cycle ops,
// hand-written sequences for multiply latency, backpressure and mid-multiply reset.
module tb_alu_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        co;
    logic        overflow;
    logic        zero;

    int total;
    int bad;

    alu_pipe #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .co       (co),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic run_mul(input int id, input logic [15:0] ma, input logic [15:0] mb,
                           input logic [15:0] exp_res, input logic exp_ov);
        @(negedge clk);
        in_valid = 1'b1; op = 3'd7; a = ma; b = mb;
        @(posedge clk); #1;
        chk("mul_acc_ready", id, 32'(in_ready), 32'd0);
        chk("mul_acc_valid", id, 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k < 16) begin
                if (in_ready !== 1'b0 || out_valid !== 1'b0)
                    chk("mul_busy", id * 100 + k, {30'd0, in_ready, out_valid}, 32'd0);
            end else begin
                chk("mul_valid", id, 32'(out_valid), 32'd1);
                chk("mul_res", id, 32'(result), 32'(exp_res));
                chk("mul_ov", id, 32'(overflow), 32'(exp_ov));
                chk("mul_co", id, 32'(co), 32'd0);
                chk("mul_zero", id, 32'(zero), 32'd0);
                chk("mul_done_ready", id, 32'(in_ready), 32'd1);
            end
        end
        @(posedge clk); #1;
        chk("mul_consumed", id, 32'(out_valid), 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        //            op    a        b        res      co    ov    z
        tbl[0]  = '{3'd0, 16'd100, 16'd120, 16'd220, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{3'd1, 16'd100, 16'd120, 16'hFFEC, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{3'd1, 16'd5,   16'd5,   16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{3'd3, 16'h000F, 16'h00F0, 16'h00FF, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3'd4, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{3'd5, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{3'd5, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{3'd5, 16'h0001, 16'h00FF, 16'h8000, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{3'd6, 16'h8001, 16'h0001, 16'h4000, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{3'd6, 16'hC000, 16'h000F, 16'h0001, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{3'd6, 16'h8000, 16'h0010, 16'h8000, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; op = 3'd0; a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_res", 0, 32'(result), 32'd0);
        chk("rst_flags", 0, {29'd0, co, overflow, zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 0, 32'(in_ready), 32'd1);

        // back-to-back single-cycle ops at full throughput
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
            @(posedge clk); #1;
            chk("vec_valid", i, 32'(out_valid), 32'd1);
            chk("vec_res", i, 32'(result), 32'(tbl[i].res));
            chk("vec_co", i, 32'(co), 32'(tbl[i].co));
            chk("vec_ov", i, 32'(overflow), 32'(tbl[i].ov));
            chk("vec_zero", i, 32'(zero), 32'(tbl[i].z));
            chk("vec_ready", i, 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain_valid", 0, 32'(out_valid), 32'd0);

        run_mul(1, 16'd300, 16'd300, 16'h5F90, 1'b1);
        run_mul(2, 16'd255, 16'd255, 16'hFE01, 1'b0);

        // backpressure: result frozen, stray in_valid must not be captured
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd2; a = 16'hF0F0; b = 16'hFF00;
        @(posedge clk); #1;
        chk("bp_first", 0, {15'd0, out_valid, result}, {15'd0, 1'b1, 16'hF000});
        @(negedge clk);
        op = 3'd4; a = 16'h1111; b = 16'h2222;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_hold", k, {14'd0, in_ready, out_valid, result}, {14'd0, 1'b0, 1'b1, 16'hF000});
        end
        @(negedge clk);
        out_ready = 1'b1; op = 3'd3; a = 16'h000F; b = 16'h00F0;
        #1;
        chk("bp_release_ready", 0, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_swap", 0, {15'd0, out_valid, result}, {15'd0, 1'b1, 16'h00FF});
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_drain", 0, 32'(out_valid), 32'd0);

        // reset on the edge of the 8th multiply iteration
        @(negedge clk);
        in_valid = 1'b1; op = 3'd7; a = 16'd300; b = 16'd300;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_outs", 0, {12'd0, out_valid, co, overflow, zero, result}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                chk("mrst_idle", k, {30'd0, out_valid, in_ready}, 32'd1);
        end
        chk("mrst_after", 0, {14'd0, in_ready, out_valid, result}, {14'd0, 1'b1, 1'b0, 16'h0000});
        @(negedge clk);
        in_valid = 1'b1; op = 3'd5; a = 16'h8001; b = 16'h0001;
        @(posedge clk); #1;
        chk("mrst_sll", 0, {14'd0, out_valid, co, result}, {14'd0, 1'b1, 1'b1, 16'h0002});
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
